// File: rtl/gemini_cache_pkg.sv
// Shared cache definitions: default line geometry, refill FSM states and the line-align helper.
package gemini_cache_pkg;

   localparam int DEF_LINE_WORDS = 8;
   localparam int WORD_W         = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2,
      ST_DONE = 2'd3
   } refill_state_t;

   // Clear the word-offset and byte-offset bits of a byte address.
   function automatic logic [31:0] line_align(input logic [31:0] addr, input int unsigned off_w);
      logic [31:0] mask;
      mask = (32'd1 << (off_w + 32'd2)) - 32'd1;
      return addr & ~mask;
   endfunction

endpackage

// File: rtl/icache_refill_if.sv
// Instruction read port between the refill engine (master) and the cache/AXI arbiter (slave).
interface icache_refill_if;

   logic [31:0] i_araddr;
   logic [7:0]  i_arlen;
   logic        i_arvalid;
   logic        i_arready;
   logic [31:0] i_rdata;
   logic        i_rlast;
   logic        i_rvalid;
   logic        i_rready;

   modport master (
      output i_araddr, i_arlen, i_arvalid, i_rready,
      input  i_arready, i_rdata, i_rlast, i_rvalid
   );

   modport slave (
      input  i_araddr, i_arlen, i_arvalid, i_rready,
      output i_arready, i_rdata, i_rlast, i_rvalid
   );

endinterface

// File: rtl/icache_line_buf.sv
// Line assembly buffer: LINE_WORDS x WORD_W registers with indexed write, clear and flat read-out.
module icache_line_buf
   import gemini_cache_pkg::*;
#(
   parameter int LINE_WORDS = DEF_LINE_WORDS,
   parameter int OFF_W      = $clog2(LINE_WORDS)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         clr,
   input  logic                         we,
   input  logic [OFF_W-1:0]             widx,
   input  logic [WORD_W-1:0]            wdata,
   output logic [LINE_WORDS*WORD_W-1:0] data
);

   logic [LINE_WORDS-1:0][WORD_W-1:0] mem;

   // Word storage; clear has priority over a write.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem <= {(LINE_WORDS*WORD_W){1'b0}};
      end else if (clr) begin
         mem <= {(LINE_WORDS*WORD_W){1'b0}};
      end else if (we) begin
         mem[widx] <= wdata;
      end
   end

   assign data = mem;

endmodule

// File: rtl/icache_refill.sv
// I-cache miss refill engine: one read burst per line miss, assembled into a line buffer.
// Optional ICACHE_CRITICAL_WORD_FIRST_EN: burst starts at the missed word, which is pulsed out early.
module icache_refill
   import gemini_cache_pkg::*;
#(
   parameter int LINE_WORDS = DEF_LINE_WORDS,
   parameter int OFF_W      = $clog2(LINE_WORDS)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         miss_req,
   input  logic [31:0]                  miss_addr,
   output logic                         miss_ready,
   output logic                         refill_valid,
   output logic [31:0]                  refill_addr,
   output logic [LINE_WORDS*WORD_W-1:0] refill_data,
   output logic                         refill_err,
   input  logic                         refill_ack,
   output logic                         crit_valid,
   output logic [31:0]                  crit_data,
   icache_refill_if.master              bus
);

   localparam logic [OFF_W:0] CNT_FULL = (OFF_W+1)'(LINE_WORDS);
   localparam logic [OFF_W:0] CNT_LAST = (OFF_W+1)'(LINE_WORDS - 1);
   localparam logic [7:0]     ARLEN    = 8'(LINE_WORDS - 1);

   refill_state_t    state;
   refill_state_t    next_state;
   logic [31:0]      addr_q;
   logic [OFF_W:0]   cnt;
   logic             err;
   logic             accept;
   logic             beat;
   logic             we;
   logic [OFF_W-1:0] start_idx;
   logic [OFF_W-1:0] widx;

   assign accept = (state == ST_IDLE) && miss_req;
   assign beat   = (state == ST_DATA) && bus.i_rvalid;
   assign we     = beat && (cnt != CNT_FULL);
   assign widx   = start_idx + cnt[OFF_W-1:0];

`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
   assign start_idx    = addr_q[OFF_W+1:2];
   assign bus.i_araddr = {addr_q[31:2], 2'b00};

   // Capture the first beat of the burst, i.e. the missed word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         crit_valid <= 1'b0;
         crit_data  <= 32'd0;
      end else begin
         crit_valid <= beat && (cnt == {(OFF_W+1){1'b0}});
         if (beat && (cnt == {(OFF_W+1){1'b0}})) begin
            crit_data <= bus.i_rdata;
         end
      end
   end
`else
   assign start_idx    = {OFF_W{1'b0}};
   assign bus.i_araddr = line_align(addr_q, OFF_W);
   assign crit_valid   = 1'b0;
   assign crit_data    = 32'd0;
`endif

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // FSM next-state logic.
   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE: if (miss_req)                   next_state = ST_ADDR; else next_state = ST_IDLE;
         ST_ADDR: if (bus.i_arready)              next_state = ST_DATA; else next_state = ST_ADDR;
         ST_DATA: if (beat && bus.i_rlast)        next_state = ST_DONE; else next_state = ST_DATA;
         ST_DONE: if (refill_ack)                 next_state = ST_IDLE; else next_state = ST_DONE;
         default:                                 next_state = ST_IDLE;
      endcase
   end

   // Request latch, beat counter and length-error tracking.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q <= 32'd0;
         cnt    <= {(OFF_W+1){1'b0}};
         err    <= 1'b0;
      end else if (accept) begin
         addr_q <= miss_addr;
         cnt    <= {(OFF_W+1){1'b0}};
         err    <= 1'b0;
      end else if (beat) begin
         if (cnt != CNT_FULL) begin
            cnt <= cnt + (OFF_W+1)'(1);
         end
         // Early rlast or any beat past a full line flags a length error.
         if ((cnt == CNT_FULL) || (bus.i_rlast && (cnt != CNT_LAST))) begin
            err <= 1'b1;
         end
      end
   end

   assign miss_ready    = (state == ST_IDLE);
   assign bus.i_arvalid = (state == ST_ADDR);
   assign bus.i_arlen   = (state == ST_ADDR) ? ARLEN : 8'd0;
   assign bus.i_rready  = (state == ST_DATA);
   assign refill_valid  = (state == ST_DONE);
   assign refill_err    = (state == ST_DONE) && err;
   assign refill_addr   = line_align(addr_q, OFF_W);

   icache_line_buf #(
      .LINE_WORDS (LINE_WORDS),
      .OFF_W      (OFF_W)
   ) u_line_buf (
      .clk   (clk),
      .rst   (rst),
      .clr   (accept),
      .we    (we),
      .widx  (widx),
      .wdata (bus.i_rdata),
      .data  (refill_data)
   );

endmodule

// File: tb/tb_icache_refill.sv
// Directed bench for icache_refill; build with or without ICACHE_CRITICAL_WORD_FIRST_EN.
module tb_icache_refill;
   import gemini_cache_pkg::*;

   localparam int LW = 8;

   logic            clk;
   logic            rst;
   logic            miss_req;
   logic [31:0]     miss_addr;
   logic            miss_ready;
   logic            refill_valid;
   logic [31:0]     refill_addr;
   logic [LW*32-1:0] refill_data;
   logic            refill_err;
   logic            refill_ack;
   logic            crit_valid;
   logic [31:0]     crit_data;

   icache_refill_if bus ();

   icache_refill #(.LINE_WORDS(LW)) dut (
      .clk          (clk),
      .rst          (rst),
      .miss_req     (miss_req),
      .miss_addr    (miss_addr),
      .miss_ready   (miss_ready),
      .refill_valid (refill_valid),
      .refill_addr  (refill_addr),
      .refill_data  (refill_data),
      .refill_err   (refill_err),
      .refill_ack   (refill_ack),
      .crit_valid   (crit_valid),
      .crit_data    (crit_data),
      .bus          (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      int          ar_delay;
      int          gap;
      int          n_beats;
      logic [31:0] araddr_line;
      logic [31:0] araddr_word;
      int          start_word;
      logic [31:0] line_addr;
      logic        exp_err;
   } vec_t;

   vec_t vecs[5];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] bd(input int v, input int b);
      return 32'hA000_0000 + 32'(v * 256 + b);
   endfunction

   task automatic run_refill(input int v);
      logic [31:0] exp_line[LW];
      logic [31:0] exp_ar;
      int          start;
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
      exp_ar = vecs[v].araddr_word;
      start  = vecs[v].start_word;
`else
      exp_ar = vecs[v].araddr_line;
      start  = 0;
`endif
      for (int k = 0; k < LW; k++) exp_line[k] = 32'd0;
      for (int b = 0; b < vecs[v].n_beats && b < LW; b++) exp_line[(start + b) % LW] = bd(v, b);

      chk("miss_ready_idle", {31'd0, miss_ready}, 32'd1);
      miss_req  = 1'b1;
      miss_addr = vecs[v].addr;
      @(posedge clk); #1;
      miss_req  = 1'b0;
      miss_addr = 32'd0;
      chk("miss_ready_busy", {31'd0, miss_ready}, 32'd0);

      for (int d = 0; d <= vecs[v].ar_delay; d++) begin
         chk("arvalid_hold", {31'd0, bus.i_arvalid}, 32'd1);
         chk("araddr", bus.i_araddr, exp_ar);
         chk("arlen", {24'd0, bus.i_arlen}, 32'd7);
         chk("rready_in_addr", {31'd0, bus.i_rready}, 32'd0);
         if (d == vecs[v].ar_delay) bus.i_arready = 1'b1;
         @(posedge clk); #1;
      end
      bus.i_arready = 1'b0;
      chk("arvalid_drop", {31'd0, bus.i_arvalid}, 32'd0);
      chk("rready_in_data", {31'd0, bus.i_rready}, 32'd1);

      for (int b = 0; b < vecs[v].n_beats; b++) begin
         repeat (vecs[v].gap) begin
            @(posedge clk); #1;
         end
         bus.i_rvalid = 1'b1;
         bus.i_rdata  = bd(v, b);
         bus.i_rlast  = (b == vecs[v].n_beats - 1);
         @(posedge clk); #1;
         bus.i_rvalid = 1'b0;
         bus.i_rlast  = 1'b0;
         bus.i_rdata  = 32'd0;
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
         chk("crit_valid", {31'd0, crit_valid}, (b == 0) ? 32'd1 : 32'd0);
         if (b == 0) chk("crit_data", crit_data, bd(v, 0));
`else
         chk("crit_valid_off", {31'd0, crit_valid}, 32'd0);
         chk("crit_data_off", crit_data, 32'd0);
`endif
         if (b < vecs[v].n_beats - 1) chk("refill_valid_early", {31'd0, refill_valid}, 32'd0);
      end

      chk("refill_valid", {31'd0, refill_valid}, 32'd1);
      chk("refill_err", {31'd0, refill_err}, {31'd0, vecs[v].exp_err});
      chk("refill_addr", refill_addr, vecs[v].line_addr);
      for (int k = 0; k < LW; k++) chk($sformatf("v%0d_word%0d", v, k), refill_data[32*k +: 32], exp_line[k]);

      @(posedge clk); #1;
      chk("refill_valid_held", {31'd0, refill_valid}, 32'd1);
      chk("refill_data_stable", refill_data[31:0], exp_line[0]);
      refill_ack = 1'b1;
      @(posedge clk); #1;
      refill_ack = 1'b0;
      chk("refill_valid_cleared", {31'd0, refill_valid}, 32'd0);
      chk("miss_ready_after_ack", {31'd0, miss_ready}, 32'd1);
   endtask

   initial begin
      vecs[0] = '{32'h0000_1000, 0, 0, 8, 32'h0000_1000, 32'h0000_1000, 0, 32'h0000_1000, 1'b0};
      vecs[1] = '{32'h0000_1014, 0, 0, 8, 32'h0000_1000, 32'h0000_1014, 5, 32'h0000_1000, 1'b0};
      vecs[2] = '{32'h0000_2048, 5, 2, 8, 32'h0000_2040, 32'h0000_2048, 2, 32'h0000_2040, 1'b0};
      vecs[3] = '{32'h0000_3000, 0, 0, 6, 32'h0000_3000, 32'h0000_3000, 0, 32'h0000_3000, 1'b1};
      vecs[4] = '{32'h0000_4000, 0, 0, 9, 32'h0000_4000, 32'h0000_4000, 0, 32'h0000_4000, 1'b1};

      rst           = 1'b0;
      miss_req      = 1'b0;
      miss_addr     = 32'd0;
      refill_ack    = 1'b0;
      bus.i_arready = 1'b0;
      bus.i_rdata   = 32'd0;
      bus.i_rlast   = 1'b0;
      bus.i_rvalid  = 1'b0;
      #1 rst = 1'b1;
      #11;
      chk("rst_miss_ready", {31'd0, miss_ready}, 32'd1);
      chk("rst_refill_valid", {31'd0, refill_valid}, 32'd0);
      chk("rst_arvalid", {31'd0, bus.i_arvalid}, 32'd0);
      chk("rst_arlen", {24'd0, bus.i_arlen}, 32'd0);
      chk("rst_araddr", bus.i_araddr, 32'd0);
      chk("rst_rready", {31'd0, bus.i_rready}, 32'd0);
      chk("rst_crit_valid", {31'd0, crit_valid}, 32'd0);
      chk("rst_data", {31'd0, |refill_data}, 32'd0);
      #2 rst = 1'b0;
      @(posedge clk); #1;

      for (int v = 0; v < 5; v++) run_refill(v);

      // Reset in the middle of a burst, after three beats.
      miss_req  = 1'b1;
      miss_addr = 32'h0000_5000;
      @(posedge clk); #1;
      miss_req      = 1'b0;
      bus.i_arready = 1'b1;
      @(posedge clk); #1;
      bus.i_arready = 1'b0;
      for (int b = 0; b < 3; b++) begin
         bus.i_rvalid = 1'b1;
         bus.i_rdata  = 32'hBEEF_0000 + 32'(b);
         @(posedge clk); #1;
      end
      bus.i_rvalid = 1'b0;
      chk("pre_rst_rready", {31'd0, bus.i_rready}, 32'd1);
      rst = 1'b1;
      #1;
      chk("midrst_miss_ready", {31'd0, miss_ready}, 32'd1);
      chk("midrst_rready", {31'd0, bus.i_rready}, 32'd0);
      chk("midrst_refill_valid", {31'd0, refill_valid}, 32'd0);
      chk("midrst_data", {31'd0, |refill_data}, 32'd0);
      chk("midrst_refill_addr", refill_addr, 32'd0);
      #1 rst = 1'b0;
      @(posedge clk); #1;
      run_refill(0);

      // Request held through DONE is taken only on the cycle after the ack.
      miss_req  = 1'b1;
      miss_addr = 32'h0000_6000;
      @(posedge clk); #1;
      miss_req      = 1'b0;
      bus.i_arready = 1'b1;
      @(posedge clk); #1;
      bus.i_arready = 1'b0;
      for (int b = 0; b < LW; b++) begin
         bus.i_rvalid = 1'b1;
         bus.i_rdata  = 32'hC000_0000 + 32'(b);
         bus.i_rlast  = (b == LW - 1);
         @(posedge clk); #1;
      end
      bus.i_rvalid = 1'b0;
      bus.i_rlast  = 1'b0;
      chk("held_refill_valid", {31'd0, refill_valid}, 32'd1);
      chk("held_word7", refill_data[32*7 +: 32], 32'hC000_0007);
      miss_req  = 1'b1;
      miss_addr = 32'h0000_7000;
      @(posedge clk); #1;
      chk("held_not_ready_done", {31'd0, miss_ready}, 32'd0);
      chk("held_no_arvalid", {31'd0, bus.i_arvalid}, 32'd0);
      refill_ack = 1'b1;
      @(posedge clk); #1;
      refill_ack = 1'b0;
      chk("held_idle_after_ack", {31'd0, miss_ready}, 32'd1);
      chk("held_no_arvalid_ack", {31'd0, bus.i_arvalid}, 32'd0);
      @(posedge clk); #1;
      miss_req = 1'b0;
      chk("held_accepted", {31'd0, miss_ready}, 32'd0);
      chk("held_arvalid", {31'd0, bus.i_arvalid}, 32'd1);
      chk("held_araddr", bus.i_araddr, 32'h0000_7000);

      rst = 1'b1;
      #2 rst = 1'b0;
      @(posedge clk); #1;
      chk("final_idle", {31'd0, miss_ready}, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
